// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants and helpers for the VGA timing generator
// and the colour blocks that consume its pixel coordinates.
package vga_timing_pkg;

  localparam int unsigned CNT_W     = 10;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_ACT_ST  = 144;
  localparam int unsigned H_ACT_END = 783;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_ACT_ST  = 35;
  localparam int unsigned V_ACT_END = 514;

  // Screen origin that colour blocks subtract from hCount/vCount.
  localparam int unsigned VGA_SCREEN_X0 = 144;
  localparam int unsigned VGA_SCREEN_Y0 = 35;

  typedef logic [CNT_W-1:0] coord_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_div.sv
// Pixel-rate divider: emits a registered one-clk pix_en pulse every CLK_DIV clks.
module pix_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      pix_en  <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel counters plus registered sync/bright/frame_tick decode
// aligned with the counter values they describe.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int unsigned H_TOTAL   = vga_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_ACT_ST  = vga_timing_pkg::H_ACT_ST,
  parameter int unsigned H_ACT_END = vga_timing_pkg::H_ACT_END,
  parameter int unsigned V_TOTAL   = vga_timing_pkg::V_TOTAL,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_ACT_ST  = vga_timing_pkg::V_ACT_ST,
  parameter int unsigned V_ACT_END = vga_timing_pkg::V_ACT_END
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] H_ST_C   = 10'(H_ACT_ST);
  localparam logic [9:0] H_END_C  = 10'(H_ACT_END);
  localparam logic [9:0] V_ST_C   = 10'(V_ACT_ST);
  localparam logic [9:0] V_END_C  = 10'(V_ACT_END);

  logic [9:0] h_next;
  logic [9:0] v_next;

  pix_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_next = hCount;
    v_next = vCount;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_next = '0;
        v_next = (vCount == V_LAST) ? '0 : vCount + 10'd1;
      end else begin
        h_next = hCount + 10'd1;
      end
    end
  end

  // Decode from next-state counters so outputs switch on the same edge as the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hCount     <= h_next;
      vCount     <= v_next;
      hSync      <= !(h_next < H_SYNC_C);
      vSync      <= !(v_next < V_SYNC_C);
      bright     <= vga_timing_pkg::in_range(h_next, H_ST_C, H_END_C) &&
                    vga_timing_pkg::in_range(v_next, V_ST_C, V_END_C);
      frame_tick <= pix_en && (hCount == H_LAST) && (vCount == V_LAST);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level checks, scaled-down
// instance (2 clk/pixel, 20x12 frame) for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       a_pix, a_hs, a_vs, a_br, a_ft;
  logic [9:0] a_h, a_v;
  logic       b_pix, b_hs, b_vs, b_br, b_ft;
  logic [9:0] b_h, b_v;

  int total = 0;
  int bad   = 0;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .frame_tick(a_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_ST(5), .H_ACT_END(16),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_ST(3), .V_ACT_END(9)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(b_pix), .hCount(b_h), .vCount(b_v),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .frame_tick(b_ft)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, lo, hi, ones, gaps, last, cnt, br, per, vlo;
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(10);

    chk("rst_pix_en", a_pix, 0);
    chk("rst_h", a_h, 0);
    chk("rst_v", a_v, 0);
    chk("rst_hsync", a_hs, 0);
    chk("rst_vsync", a_vs, 0);
    chk("rst_bright", a_br, 0);
    chk("rst_ftick", a_ft, 0);

    rst_a = 1'b1;
    step(3);
    chk("pix_en_before_4", a_pix, 0);
    step(1);
    chk("first_pix_en", a_pix, 1);
    chk("h_at_first_pulse", a_h, 0);
    chk("no_ftick_on_release", a_ft, 0);
    step(1);
    chk("h_after_first_pulse", a_h, 1);
    chk("pix_en_one_clk", a_pix, 0);

    ones = 0; gaps = 0; last = -1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (a_pix) begin
        ones++;
        if (last >= 0 && i - last != 4) gaps++;
        last = i;
      end
    end
    chk("div_pulses_100", ones, 25);
    chk("div_bad_gaps", gaps, 0);

    n = 0;
    while (a_h != 0 && n < 4000) begin step(1); n++; end
    chk("hsync_align", a_h, 0);
    lo = 0; hi = 0;
    for (int i = 0; i < 3200; i++) begin
      if (a_hs) hi++; else lo++;
      step(1);
    end
    chk("hsync_low_clks", lo, 384);
    chk("hsync_high_clks", hi, 2816);
    chk("line_period_h", a_h, 0);

    n = 0;
    while (!(a_h == 10'd799 && a_v == 10'd10 && a_pix) && n < 40000) begin step(1); n++; end
    chk("line_wrap_reached", (n < 40000), 1);
    chk("bright_v10", a_br, 0);
    step(1);
    chk("line_wrap_h", a_h, 0);
    chk("line_wrap_v", a_v, 11);
    chk("line_wrap_hsync", a_hs, 0);
    chk("line_wrap_ftick", a_ft, 0);

    rst_b = 1'b1;
    n = 0;
    while (!b_br && n < 1000) begin step(1); n++; end
    chk("bright_rise_h", b_h, 5);
    chk("bright_rise_v", b_v, 3);
    n = 0;
    while (b_br && n < 1000) begin step(1); n++; end
    chk("bright_fall_h", b_h, 17);
    chk("bright_fall_v", b_v, 3);

    n = 0;
    while (b_v != 10'd10 && n < 1000) begin step(1); n++; end
    cnt = 0; br = 0;
    while (b_v == 10'd10 && cnt < 100) begin
      if (b_br) br++;
      cnt++;
      step(1);
    end
    chk("bright_past_end_line", br, 0);
    chk("past_end_line_clks", cnt, 40);

    n = 0;
    while (!b_ft && n < 1000) begin step(1); n++; end
    chk("frame_wrap_h", b_h, 0);
    chk("frame_wrap_v", b_v, 0);
    vlo = b_vs ? 0 : 1;
    step(1);
    per = 1;
    chk("ftick_width", b_ft, 0);
    while (!b_ft && per < 1000) begin
      if (!b_vs) vlo++;
      step(1);
      per++;
    end
    chk("frame_period", per, 480);
    chk("vsync_low_clks", vlo, 80);

    n = 0;
    while (!(b_h == 10'd10 && b_v == 10'd6) && n < 1000) begin step(1); n++; end
    chk("midframe_reached", (n < 1000), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_h", b_h, 0);
    chk("async_rst_v", b_v, 0);
    chk("async_rst_hsync", b_hs, 0);
    chk("async_rst_bright", b_br, 0);
    chk("async_rst_pix", b_pix, 0);
    step(3);
    chk("rst_hold_h", b_h, 0);
    rst_b = 1'b1;
    n = 0;
    while (!b_ft && n < 1000) begin step(1); n++; end
    chk("ftick_after_rst_clks", n, 481);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
